// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Opcodes, state codes and datapath mux selects.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BNE      = 4'd12,
    S_FAULT    = 4'd15
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) ||
           (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Saturating wait counter for outstanding memory requests.
// Flags expiry once the count reaches the configured limit.
module mem_wait_timer #(
  parameter int unsigned TO_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            count_en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q >= limit);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main controller: sequences each instruction
// and drives datapath selects and write enables.
module multicycle_control_fsm
  import mips_mc_pkg::*;
#(
  parameter bit          ENABLE_EXT  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic       Fault,
  output logic [1:0] FaultCode,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic in_mem;
  logic expired;

  logic mem_req, mem_write, ir_write;
  logic reg_write, pc_write, branch;
  logic branch_ne;

  assign in_mem = is_mem_state(state_q);

  mem_wait_timer #(
    .TO_W(TO_W)
  ) u_timer (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clear   (!in_mem || MemReady),
    .count_en(in_mem && !MemReady),
    .limit   (TO_W'(MEM_TIMEOUT)),
    .expired (expired)
  );

  // A late MemReady still beats the timeout in the same cycle
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    unique case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (Opcode == OP_RTYPE):
            state_d = S_EXECUTE;
          (Opcode == OP_LW),
          (Opcode == OP_SW):
            state_d = S_MEMADR;
          (Opcode == OP_BEQ):
            state_d = S_BRANCH;
          (ENABLE_EXT && (Opcode == OP_ADDI)):
            state_d = S_ADDIEX;
          (ENABLE_EXT && (Opcode == OP_J)):
            state_d = S_JUMP;
          (ENABLE_EXT && (Opcode == OP_BNE)):
            state_d = S_BNE;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (Opcode == OP_SW) ? S_MEMWRITE
                                    : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_BNE,
      S_JUMP:    state_d = S_FETCH;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_FETCH;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    ALUOp     = ALUOP_ADD;
    PCSrc     = PCSRC_ALU;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ir_write = MemReady;
        pc_write = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
      end
      S_MEMADR,
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        IorD      = 1'b1;
        mem_write = MemReady;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH,
      S_BNE: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_SUB;
        PCSrc     = PCSRC_ALUOUT;
        branch    = 1'b1;
        branch_ne = (state_q == S_BNE);
      end
      S_JUMP: begin
        PCSrc    = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Enables are forced low for as long as reset is held
  assign MemReq    = mem_req & Reset_n;
  assign MemWrite  = mem_write & Reset_n;
  assign IRWrite   = ir_write & Reset_n;
  assign RegWrite  = reg_write & Reset_n;
  assign PCWrite   = pc_write & Reset_n;
  assign Branch    = branch & Reset_n;
  assign PCEn      = PCWrite |
                     (Branch & (Zero ^ branch_ne));
  assign Fault     = (state_q == S_FAULT);
  assign FaultCode = fault_code_q;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle main controller.
// Runs one extended and one base-opcode-only instance.
module tb_multicycle_control_fsm;

  logic       Clk;
  logic       Reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;

  logic       MemReq, IorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCWrite, Branch, PCEn, Fault;
  logic [1:0] FaultCode;
  logic [3:0] State;

  logic       MemReq0, IorD0, MemWrite0, IRWrite0;
  logic       RegDst0, MemtoReg0, RegWrite0, ALUSrcA0;
  logic [1:0] ALUSrcB0, ALUOp0, PCSrc0;
  logic       PCWrite0, Branch0, PCEn0, Fault0;
  logic [1:0] FaultCode0;
  logic [3:0] State0;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm #(
    .ENABLE_EXT(1'b1), .MEM_TIMEOUT(15), .TO_W(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode),
    .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
    .PCEn(PCEn), .Fault(Fault), .FaultCode(FaultCode),
    .State(State)
  );

  multicycle_control_fsm #(
    .ENABLE_EXT(1'b0), .MEM_TIMEOUT(15), .TO_W(4)
  ) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode),
    .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq0), .IorD(IorD0), .MemWrite(MemWrite0),
    .IRWrite(IRWrite0), .RegDst(RegDst0),
    .MemtoReg(MemtoReg0), .RegWrite(RegWrite0),
    .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0),
    .PCSrc(PCSrc0), .PCWrite(PCWrite0), .Branch(Branch0),
    .PCEn(PCEn0), .Fault(Fault0), .FaultCode(FaultCode0),
    .State(State0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset_n  = 1'b0;
    MemReady = 1'b1;
    Opcode   = 6'b000000;
    Zero     = 1'b0;
    #2;
    chk("rst_state", State, 4'd0);
    chk("rst_memreq", {3'b0, MemReq}, 4'd0);
    chk("rst_irwrite", {3'b0, IRWrite}, 4'd0);
    chk("rst_pcwrite", {3'b0, PCWrite}, 4'd0);
    chk("rst_pcen", {3'b0, PCEn}, 4'd0);
    chk("rst_alusrcb", {2'b0, ALUSrcB}, 4'd1);
    chk("rst_aluop", {2'b0, ALUOp}, 4'd0);
    chk("rst_faultcode", {2'b0, FaultCode}, 4'd0);

    // lw, MemReady always high
    tick();
    Reset_n = 1'b1;
    Opcode  = 6'b100011;
    #1;
    chk("lw_fetch_state", State, 4'd0);
    chk("lw_fetch_memreq", {3'b0, MemReq}, 4'd1);
    chk("lw_fetch_irwrite", {3'b0, IRWrite}, 4'd1);
    chk("lw_fetch_pcen", {3'b0, PCEn}, 4'd1);
    chk("lw_fetch_regwr", {3'b0, RegWrite}, 4'd0);
    nxt();
    chk("lw_dec_state", State, 4'd1);
    chk("lw_dec_srcb", {2'b0, ALUSrcB}, 4'd3);
    chk("lw_dec_regwr", {3'b0, RegWrite}, 4'd0);
    nxt();
    chk("lw_adr_state", State, 4'd2);
    chk("lw_adr_srca", {3'b0, ALUSrcA}, 4'd1);
    chk("lw_adr_srcb", {2'b0, ALUSrcB}, 4'd2);
    nxt();
    chk("lw_rd_state", State, 4'd3);
    chk("lw_rd_iord", {3'b0, IorD}, 4'd1);
    chk("lw_rd_memreq", {3'b0, MemReq}, 4'd1);
    chk("lw_rd_regwr", {3'b0, RegWrite}, 4'd0);
    nxt();
    chk("lw_wb_state", State, 4'd4);
    chk("lw_wb_regwr", {3'b0, RegWrite}, 4'd1);
    chk("lw_wb_memtoreg", {3'b0, MemtoReg}, 4'd1);
    chk("lw_wb_regdst", {3'b0, RegDst}, 4'd0);
    nxt();
    chk("lw_done_state", State, 4'd0);

    // sw with three stalled cycles
    Opcode = 6'b101011;
    nxt();
    nxt();
    chk("sw_adr_state", State, 4'd2);
    tick();
    MemReady = 1'b0;
    #1;
    chk("sw_w1_state", State, 4'd5);
    chk("sw_w1_memwr", {3'b0, MemWrite}, 4'd0);
    nxt();
    chk("sw_w2_memwr", {3'b0, MemWrite}, 4'd0);
    nxt();
    chk("sw_w3_memwr", {3'b0, MemWrite}, 4'd0);
    chk("sw_w3_state", State, 4'd5);
    tick();
    MemReady = 1'b1;
    #1;
    chk("sw_w4_state", State, 4'd5);
    chk("sw_w4_memwr", {3'b0, MemWrite}, 4'd1);
    nxt();
    chk("sw_done_state", State, 4'd0);
    chk("sw_done_memwr", {3'b0, MemWrite}, 4'd0);

    // R-type abandoned by reset, then rerun
    Opcode = 6'b000000;
    nxt();
    nxt();
    chk("r_ex_state", State, 4'd6);
    chk("r_ex_aluop", {2'b0, ALUOp}, 4'd2);
    Reset_n = 1'b0;
    #1;
    chk("r_rst_state", State, 4'd0);
    chk("r_rst_memreq", {3'b0, MemReq}, 4'd0);
    chk("r_rst_regwr", {3'b0, RegWrite}, 4'd0);
    chk("r_rst_pcen", {3'b0, PCEn}, 4'd0);
    tick();
    Reset_n = 1'b1;
    #1;
    chk("r_rel_state", State, 4'd0);
    chk("r_rel_memreq", {3'b0, MemReq}, 4'd1);
    nxt();
    nxt();
    chk("r_ex2_state", State, 4'd6);
    nxt();
    chk("r_wb_state", State, 4'd7);
    chk("r_wb_regwr", {3'b0, RegWrite}, 4'd1);
    chk("r_wb_regdst", {3'b0, RegDst}, 4'd1);
    chk("r_wb_memtoreg", {3'b0, MemtoReg}, 4'd0);
    nxt();
    chk("r_done_state", State, 4'd0);

    // beq taken
    Opcode = 6'b000100;
    Zero   = 1'b1;
    nxt();
    nxt();
    chk("beq_state", State, 4'd8);
    chk("beq_pcen", {3'b0, PCEn}, 4'd1);
    chk("beq_pcsrc", {2'b0, PCSrc}, 4'd1);
    chk("beq_aluop", {2'b0, ALUOp}, 4'd1);
    chk("beq_branch", {3'b0, Branch}, 4'd1);
    nxt();
    chk("beq_done_state", State, 4'd0);

    // bne; the base-only instance must fault here
    Opcode = 6'b000101;
    nxt();
    nxt();
    chk("bne_state", State, 4'd12);
    chk("bne_z1_pcen", {3'b0, PCEn}, 4'd0);
    chk("bne_branch", {3'b0, Branch}, 4'd1);
    chk("noext_fault", {3'b0, Fault0}, 4'd1);
    chk("noext_code", {2'b0, FaultCode0}, 4'd1);
    chk("noext_state", State0, 4'd15);
    Zero = 1'b0;
    #1;
    chk("bne_z0_pcen", {3'b0, PCEn}, 4'd1);
    nxt();
    chk("bne_done_state", State, 4'd0);

    // jump
    Opcode = 6'b000010;
    nxt();
    nxt();
    chk("j_state", State, 4'd11);
    chk("j_pcsrc", {2'b0, PCSrc}, 4'd2);
    chk("j_pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("j_pcen", {3'b0, PCEn}, 4'd1);
    nxt();
    chk("j_done_state", State, 4'd0);

    // addi
    Opcode = 6'b001000;
    nxt();
    nxt();
    chk("addi_ex_state", State, 4'd9);
    chk("addi_ex_srcb", {2'b0, ALUSrcB}, 4'd2);
    nxt();
    chk("addi_wb_state", State, 4'd10);
    chk("addi_wb_regwr", {3'b0, RegWrite}, 4'd1);
    chk("addi_wb_regdst", {3'b0, RegDst}, 4'd0);
    chk("addi_wb_m2r", {3'b0, MemtoReg}, 4'd0);
    nxt();
    chk("addi_done_state", State, 4'd0);

    // fetch timeout: 16 stalled cycles then FAULT
    MemReady = 1'b0;
    #1;
    chk("to_c0_state", State, 4'd0);
    chk("to_c0_irwrite", {3'b0, IRWrite}, 4'd0);
    for (int i = 1; i < 16; i++) begin
      nxt();
      chk($sformatf("to_c%0d_state", i), State, 4'd0);
    end
    nxt();
    chk("to_fault_state", State, 4'd15);
    chk("to_fault", {3'b0, Fault}, 4'd1);
    chk("to_fault_code", {2'b0, FaultCode}, 4'd2);
    chk("to_fault_memreq", {3'b0, MemReq}, 4'd0);
    MemReady = 1'b1;
    nxt();
    nxt();
    chk("to_hold_state", State, 4'd15);
    Reset_n = 1'b0;
    #1;
    chk("to_rst_state", State, 4'd0);
    chk("to_rst_fault", {3'b0, Fault}, 4'd0);
    chk("to_rst_code", {2'b0, FaultCode}, 4'd0);
    tick();
    Reset_n = 1'b1;

    // MemReady arrives as the count reaches the limit
    MemReady = 1'b0;
    Opcode   = 6'b111111;
    #1;
    chk("lim_c0_state", State, 4'd0);
    for (int i = 1; i < 15; i++) begin
      nxt();
      chk($sformatf("lim_c%0d_state", i), State, 4'd0);
    end
    tick();
    MemReady = 1'b1;
    #1;
    chk("lim_c15_state", State, 4'd0);
    chk("lim_c15_irwrite", {3'b0, IRWrite}, 4'd1);
    nxt();
    chk("lim_dec_state", State, 4'd1);
    chk("lim_dec_fault", {3'b0, Fault}, 4'd0);

    // illegal opcode faults and holds until reset
    nxt();
    chk("ill_state", State, 4'd15);
    chk("ill_fault", {3'b0, Fault}, 4'd1);
    chk("ill_code", {2'b0, FaultCode}, 4'd1);
    nxt();
    nxt();
    nxt();
    chk("ill_hold_state", State, 4'd15);
    chk("ill_hold_code", {2'b0, FaultCode}, 4'd1);
    Reset_n = 1'b0;
    #1;
    chk("ill_rst_state", State, 4'd0);
    chk("ill_rst_code", {2'b0, FaultCode}, 4'd0);
    tick();
    Reset_n = 1'b1;
    Opcode  = 6'b000000;
    #1;
    chk("ill_rel_memreq", {3'b0, MemReq}, 4'd1);
    nxt();
    chk("ill_rel_state", State, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
